// File: rtl/frame_detect_fsm_if.sv
// Sample/energy inputs and detection status outputs of the frame detector.
// The master modport drives the samples; the slave modport is the detector itself.
interface frame_detect_fsm_if;
  logic        InputEnable;
  logic [20:0] Sum16Magnituder;
  logic [20:0] CorrMagnituder;
  logic        FrameDone;
  logic        DetectPulse;
  logic        Detecting;
  logic [5:0]  HitCount;
  logic [1:0]  State;

  modport master (
    output InputEnable, Sum16Magnituder, CorrMagnituder, FrameDone,
    input  DetectPulse, Detecting, HitCount, State
  );

  modport slave (
    input  InputEnable, Sum16Magnituder, CorrMagnituder, FrameDone,
    output DetectPulse, Detecting, HitCount, State
  );
endinterface

// File: rtl/frame_detect_fsm.sv
// Frame detector: registered threshold compare, then IDLE/COUNT/LOCKED/HOLDOFF FSM.
// DetectPulse rises 2 clocks after the completing sample; no backpressure, one sample per clock.
module frame_detect_fsm #(
  parameter int          HIT_NUM      = 32,
  parameter int          MISS_TOL     = 4,
  parameter logic [20:0] ENERGY_MIN   = 21'd4096,
  parameter int          LOCK_TIMEOUT = 2048,
  parameter int          HOLDOFF_LEN  = 64
) (
  input logic               Clk,
  input logic               Rst_n,
  frame_detect_fsm_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COUNT   = 2'd1,
    S_LOCKED  = 2'd2,
    S_HOLDOFF = 2'd3
  } state_e;

  localparam logic [5:0]  HIT_LIM  = 6'(HIT_NUM);
  localparam logic [3:0]  MISS_LIM = 4'(MISS_TOL);
  localparam logic [12:0] LOCK_LIM = 13'(LOCK_TIMEOUT);
  localparam logic [7:0]  HOLD_LIM = 8'(HOLDOFF_LEN - 1);

  // Stage 1: 4*Corr >= 3*Sum evaluated at 23 bits so neither side can overflow.
  logic [22:0] corr_x4;
  logic [22:0] sum_x3;
  logic        hit_raw;
  logic        hit_vld_q;
  logic        hit_q;

  assign corr_x4 = {bus.CorrMagnituder, 2'b00};
  assign sum_x3  = {2'b00, bus.Sum16Magnituder} + {1'b0, bus.Sum16Magnituder, 1'b0};
  assign hit_raw = (corr_x4 >= sum_x3) && (bus.Sum16Magnituder >= ENERGY_MIN);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      hit_vld_q <= 1'b0;
      hit_q     <= 1'b0;
    end else begin
      hit_vld_q <= bus.InputEnable;
      hit_q     <= bus.InputEnable & hit_raw;
    end
  end

  state_e      state_q, state_d;
  logic [5:0]  hit_cnt_q, hit_cnt_d;
  logic [2:0]  miss_cnt_q, miss_cnt_d;
  logic [11:0] lock_cnt_q, lock_cnt_d;
  logic [7:0]  hold_cnt_q, hold_cnt_d;
  logic        det_pulse_q, det_pulse_d;

  logic [5:0]  hit_cnt_inc;
  logic [3:0]  miss_cnt_inc;
  logic [12:0] lock_cnt_inc;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= S_IDLE;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      lock_cnt_q  <= '0;
      hold_cnt_q  <= '0;
      det_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      lock_cnt_q  <= lock_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      det_pulse_q <= det_pulse_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    lock_cnt_d   = lock_cnt_q;
    hold_cnt_d   = hold_cnt_q;
    det_pulse_d  = 1'b0;
    hit_cnt_inc  = (hit_cnt_q == 6'd63) ? hit_cnt_q : hit_cnt_q + 6'd1;
    miss_cnt_inc = {1'b0, miss_cnt_q} + 4'd1;
    lock_cnt_inc = {1'b0, lock_cnt_q} + 13'd1;

    unique case (state_q)
      S_IDLE: begin
        if (hit_vld_q && hit_q) begin
          state_d    = S_COUNT;
          hit_cnt_d  = 6'd1;
          miss_cnt_d = '0;
        end
      end
      S_COUNT: begin
        // A completing hit takes priority over a gap seen in the same cycle.
        if (hit_vld_q && hit_q && (hit_cnt_inc == HIT_LIM)) begin
          state_d     = S_LOCKED;
          hit_cnt_d   = hit_cnt_inc;
          lock_cnt_d  = '0;
          det_pulse_d = 1'b1;
        end else if (!bus.InputEnable || !hit_vld_q) begin
          state_d    = S_IDLE;
          hit_cnt_d  = '0;
          miss_cnt_d = '0;
        end else if (hit_q) begin
          hit_cnt_d = hit_cnt_inc;
        end else if (miss_cnt_inc > MISS_LIM) begin
          state_d    = S_IDLE;
          hit_cnt_d  = '0;
          miss_cnt_d = '0;
        end else begin
          miss_cnt_d = miss_cnt_inc[2:0];
        end
      end
      S_LOCKED: begin
        if (bus.InputEnable) begin
          lock_cnt_d = lock_cnt_inc[11:0];
        end
        if (bus.FrameDone || (bus.InputEnable && (lock_cnt_inc == LOCK_LIM))) begin
          state_d    = S_HOLDOFF;
          hold_cnt_d = '0;
        end
      end
      S_HOLDOFF: begin
        if (hold_cnt_q == HOLD_LIM) begin
          state_d    = S_IDLE;
          hit_cnt_d  = '0;
          miss_cnt_d = '0;
          lock_cnt_d = '0;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.DetectPulse = det_pulse_q;
  assign bus.Detecting   = (state_q == S_LOCKED);
  assign bus.HitCount    = hit_cnt_q;
  assign bus.State       = state_q;

endmodule

// File: tb/tb_frame_detect_fsm.sv
// Directed bench for frame_detect_fsm: threshold vector table plus multi-cycle sequences.
module tb_frame_detect_fsm;
  logic Clk;
  logic Rst_n;
  frame_detect_fsm_if bus ();

  frame_detect_fsm dut (
    .Clk  (Clk),
    .Rst_n(Rst_n),
    .bus  (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_tests = 0;
  int n_fail  = 0;
  int dp_cnt  = 0;

  always @(negedge Clk) begin
    if (bus.DetectPulse) dp_cnt <= dp_cnt + 1;
  end

  typedef struct {
    string       name;
    logic        ie;
    logic [20:0] sum;
    logic [20:0] corr;
    logic        fd;
    int          st;
    int          hc;
  } vec_t;

  vec_t tbl[8];

  localparam logic [20:0] HS = 21'd8192;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input logic ie, input logic [20:0] s, input logic [20:0] c, input logic fd);
    bus.InputEnable     = ie;
    bus.Sum16Magnituder = s;
    bus.CorrMagnituder  = c;
    bus.FrameDone       = fd;
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    bus.InputEnable     = 1'b0;
    bus.Sum16Magnituder = '0;
    bus.CorrMagnituder  = '0;
    bus.FrameDone       = 1'b0;
    Rst_n = 1'b0;
    @(posedge Clk);
    #1;
    Rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, %0d tests run", n_tests);
    $fatal(1);
  end

  initial begin
    int dp_at;
    int dp_base;

    tbl[0] = '{"thr_equal_hit",    1'b1, 21'd4096,    21'd3072,    1'b0, 1, 1};
    tbl[1] = '{"thr_below_miss",   1'b1, 21'd4096,    21'd3071,    1'b0, 0, 0};
    tbl[2] = '{"energy_floor",     1'b1, 21'd4095,    21'd8192,    1'b0, 0, 0};
    tbl[3] = '{"zero_zero_miss",   1'b1, 21'd0,       21'd0,       1'b0, 0, 0};
    tbl[4] = '{"nominal_hit",      1'b1, 21'd8192,    21'd8192,    1'b0, 1, 1};
    tbl[5] = '{"max_sum_hit",      1'b1, 21'd2097151, 21'd1572864, 1'b0, 1, 1};
    tbl[6] = '{"max_sum_miss",     1'b1, 21'd2097151, 21'd1572863, 1'b0, 0, 0};
    tbl[7] = '{"no_enable",        1'b0, 21'd4096,    21'd3072,    1'b0, 0, 0};

    bus.InputEnable     = 1'b0;
    bus.Sum16Magnituder = '0;
    bus.CorrMagnituder  = '0;
    bus.FrameDone       = 1'b0;
    Rst_n = 1'b0;
    #2;
    chk("rst_state", int'(bus.State), 0);
    chk("rst_hitcount", int'(bus.HitCount), 0);
    chk("rst_detectpulse", int'(bus.DetectPulse), 0);
    chk("rst_detecting", int'(bus.Detecting), 0);

    // Single-sample threshold cases, each from a fresh reset.
    foreach (tbl[i]) begin
      do_reset();
      cyc(tbl[i].ie, tbl[i].sum, tbl[i].corr, tbl[i].fd);
      cyc(1'b0, '0, '0, 1'b0);
      chk({tbl[i].name, "_state"}, int'(bus.State), tbl[i].st);
      chk({tbl[i].name, "_hc"}, int'(bus.HitCount), tbl[i].hc);
      chk({tbl[i].name, "_dp"}, int'(bus.DetectPulse), 0);
    end

    // Detection with 40 continuous hits, then FrameDone and HOLDOFF.
    do_reset();
    dp_at = -1;
    dp_base = dp_cnt;
    for (int k = 1; k <= 40; k++) begin
      cyc(1'b1, HS, HS, 1'b0);
      if (bus.DetectPulse && dp_at < 0) dp_at = k;
    end
    #5;
    chk("det_cycle", dp_at, 33);
    chk("det_once", dp_cnt - dp_base, 1);
    chk("det_detecting", int'(bus.Detecting), 1);
    chk("det_hitcount", int'(bus.HitCount), 32);
    chk("det_state", int'(bus.State), 2);
    cyc(1'b1, HS, HS, 1'b1);
    chk("fd_holdoff", int'(bus.State), 3);
    for (int k = 0; k < 63; k++) cyc(1'b1, HS, HS, 1'b0);
    chk("holdoff_len_63", int'(bus.State), 3);
    cyc(1'b1, HS, HS, 1'b0);
    chk("holdoff_to_idle", int'(bus.State), 0);
    #5;
    chk("holdoff_no_redetect", dp_cnt - dp_base, 1);

    // Lock timeout: gaps in LOCKED are ignored and not counted.
    do_reset();
    for (int k = 0; k < 33; k++) cyc(1'b1, HS, HS, 1'b0);
    chk("to_locked", int'(bus.State), 2);
    for (int k = 0; k < 1000; k++) cyc(1'b1, HS, HS, 1'b0);
    for (int k = 0; k < 10; k++) cyc(1'b0, '0, '0, 1'b0);
    for (int k = 0; k < 1047; k++) cyc(1'b1, HS, HS, 1'b0);
    chk("to_2047_locked", int'(bus.State), 2);
    cyc(1'b1, HS, HS, 1'b0);
    chk("to_2048_holdoff", int'(bus.State), 3);

    // Miss tolerance: 4 misses survive; the final hit coincides with a gap.
    do_reset();
    dp_base = dp_cnt;
    for (int k = 0; k < 20; k++) cyc(1'b1, HS, HS, 1'b0);
    for (int k = 0; k < 4; k++) cyc(1'b1, '0, '0, 1'b0);
    for (int k = 0; k < 12; k++) cyc(1'b1, HS, HS, 1'b0);
    cyc(1'b0, '0, '0, 1'b0);
    chk("miss4_locked", int'(bus.State), 2);
    chk("miss4_dp", int'(bus.DetectPulse), 1);

    do_reset();
    for (int k = 0; k < 20; k++) cyc(1'b1, HS, HS, 1'b0);
    for (int k = 0; k < 5; k++) cyc(1'b1, '0, '0, 1'b0);
    chk("miss4_still_count", int'(bus.State), 1);
    chk("miss4_hc20", int'(bus.HitCount), 20);
    cyc(1'b1, '0, '0, 1'b0);
    chk("miss5_idle", int'(bus.State), 0);
    chk("miss5_hc0", int'(bus.HitCount), 0);

    // Gap after 31 hits restarts the count.
    do_reset();
    dp_base = dp_cnt;
    for (int k = 0; k < 31; k++) cyc(1'b1, HS, HS, 1'b0);
    cyc(1'b0, '0, '0, 1'b0);
    cyc(1'b1, HS, HS, 1'b0);
    cyc(1'b0, '0, '0, 1'b0);
    chk("gap_state", int'(bus.State), 1);
    chk("gap_hc", int'(bus.HitCount), 1);
    #5;
    chk("gap_no_detect", dp_cnt - dp_base, 0);

    // Asynchronous reset mid-COUNT, then a fresh 32 hits are needed.
    do_reset();
    for (int k = 0; k < 30; k++) cyc(1'b1, HS, HS, 1'b0);
    chk("pre_rst_hc", int'(bus.HitCount), 29);
    Rst_n = 1'b0;
    #2;
    chk("arst_state", int'(bus.State), 0);
    chk("arst_hc", int'(bus.HitCount), 0);
    chk("arst_dp", int'(bus.DetectPulse), 0);
    @(posedge Clk);
    #1;
    Rst_n = 1'b1;
    dp_base = dp_cnt;
    for (int k = 0; k < 32; k++) cyc(1'b1, HS, HS, 1'b0);
    chk("post_rst_hc31", int'(bus.HitCount), 31);
    chk("post_rst_no_dp", int'(bus.DetectPulse), 0);
    cyc(1'b0, '0, '0, 1'b0);
    chk("post_rst_dp", int'(bus.DetectPulse), 1);
    chk("post_rst_hc32", int'(bus.HitCount), 32);
    #5;
    chk("post_rst_dp_once", dp_cnt - dp_base, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
